// File: rtl/bht_update_queue.sv
// rtl/bht_update_queue.sv - FIFO of resolved branch outcomes feeding the BHT update port
//
// Buffers resolved conditional branches from EX and drains them in order,
// one per cycle, into the BHT write port. Also counts accepted branches
// and mispredicts with saturating counters.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ex_valid/ex_ready             EX handshake; transfer on ex_valid && ex_ready
//   ex_pc, ex_taken               resolved branch payload
//   ex_pred_taken                 fetch-time prediction (counters only)
//   hold                          front end suppresses draining this cycle
//   update_valid/pc/taken         BHT write port, head of queue
//   count, full, empty            occupancy status
//   branch_cnt, mispred_cnt       saturating performance counters
module bht_update_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_valid,
    output logic                       ex_ready,
    input  logic [31:0]                ex_pc,
    input  logic                       ex_taken,
    input  logic                       ex_pred_taken,
    input  logic                       hold,
    output logic                       update_valid,
    output logic [31:0]                update_pc,
    output logic                       update_taken,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [CNT_W-1:0]           branch_cnt,
    output logic [CNT_W-1:0]           mispred_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_Q = OCC_W'(DEPTH);

    logic [31:0]      mem_pc    [DEPTH];
    logic             mem_taken [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count_q;
    logic             enq;
    logic             deq;

    assign full     = (count_q == DEPTH_Q);
    assign empty    = (count_q == '0);
    assign count    = count_q;

    // Ready depends only on occupancy, so a dequeue in the same cycle never
    // opens a slot for an incoming entry when full.
    assign ex_ready = !full;
    assign enq      = ex_valid && ex_ready;
    assign deq      = !empty && !hold;

    assign update_valid = deq;
    // Zero the payload when empty so post-reset outputs are defined even
    // though the storage itself is not reset.
    assign update_pc    = empty ? 32'h0 : mem_pc[rd_ptr];
    assign update_taken = empty ? 1'b0  : mem_taken[rd_ptr];

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_pc[wr_ptr]    <= ex_pc;
            mem_taken[wr_ptr] <= ex_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + OCC_W'(1);
                2'b01:   count_q <= count_q - OCC_W'(1);
                default: count_q <= count_q;
            endcase
            if (enq && (branch_cnt != {CNT_W{1'b1}})) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (enq && (ex_taken != ex_pred_taken) && (mispred_cnt != {CNT_W{1'b1}})) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bht_update_queue.sv
// tb/tb_bht_update_queue.sv - scoreboard bench for bht_update_queue
module tb_bht_update_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic        hold;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    bht_update_queue #(.DEPTH(8), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_pc        (ex_pc),
        .ex_taken     (ex_taken),
        .ex_pred_taken(ex_pred_taken),
        .hold         (hold),
        .update_valid (update_valid),
        .update_pc    (update_pc),
        .update_taken (update_taken),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: occupancy, expected entries, counters.
    logic [32:0] sb[$];
    int          mcount = 0;
    logic [31:0] mbranch = 0;
    logic [31:0] mmis = 0;
    int          drained = 0;

    always @(posedge clk) begin
        bit enq_m, deq_m;
        if (rst) begin
            mcount  = 0;
            mbranch = 0;
            mmis    = 0;
            sb.delete();
        end else begin
            enq_m = ex_valid && (mcount < 8);
            deq_m = (mcount != 0) && !hold;
            if (deq_m) begin
                void'(sb.pop_front());
                drained++;
            end
            if (enq_m) begin
                sb.push_back({ex_pc, ex_taken});
                mbranch++;
                if (ex_taken != ex_pred_taken) mmis++;
            end
            mcount = mcount + int'(enq_m) - int'(deq_m);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("count", 32'(count), 32'(mcount));
            chk("ex_ready", 32'(ex_ready), 32'(mcount < 8));
            chk("full", 32'(full), 32'(mcount == 8));
            chk("empty", 32'(empty), 32'(mcount == 0));
            chk("update_valid", 32'(update_valid), 32'((mcount != 0) && !hold));
            chk("branch_cnt", branch_cnt, mbranch);
            chk("mispred_cnt", mispred_cnt, mmis);
            if (mcount != 0 && sb.size() != 0) begin
                chk("update_pc", update_pc, sb[0][32:1]);
                chk("update_taken", 32'(update_taken), 32'(sb[0][0]));
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic t, input logic p);
        ex_valid      = v;
        ex_pc         = pc;
        ex_taken      = t;
        ex_pred_taken = p;
    endtask

    initial begin
        rst = 1'b1;
        hold = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(2);
        rst = 1'b0;
        cyc(2);

        // 1: idle after reset
        chk("t1_ready", 32'(ex_ready), 32'd1);
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_uvalid", 32'(update_valid), 32'd0);
        chk("t1_upc", update_pc, 32'h0);
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_bcnt", branch_cnt, 32'd0);

        // 2: single enqueue, appears next cycle, then drains
        drive(1'b1, 32'h0000_1000, 1'b1, 1'b1);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t2_uvalid", 32'(update_valid), 32'd1);
        chk("t2_upc", update_pc, 32'h1000);
        chk("t2_utaken", 32'(update_taken), 32'd1);
        cyc();
        chk("t2_empty", 32'(empty), 32'd1);
        cyc();

        // 3: fill under hold, 9th refused, then ordered drain
        hold = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), i[0], 1'b0);
            cyc();
        end
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_ready", 32'(ex_ready), 32'd0);
        chk("t3_count", 32'(count), 32'd8);
        chk("t3_uvalid_hold", 32'(update_valid), 32'd0);
        drained = 0;
        hold = 1'b0;
        chk("t3_head", update_pc, 32'h100);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(10);
        chk("t3_drained", 32'(drained), 32'd8);
        chk("t3_bcnt", branch_cnt, 32'd9);

        // 4: continuous stream, pointers wrap
        drained = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h2000 + 32'(4 * i), i[1], i[0]);
            cyc();
            chk("t4_count", 32'(count), 32'd1);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(3);
        chk("t4_drained", 32'(drained), 32'd20);
        chk("t4_bcnt", branch_cnt, 32'd29);

        // 5: mispredict counting from a clean start
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(1'b1, 32'h300, 1'b1, 1'b1); cyc();
        drive(1'b1, 32'h304, 1'b0, 1'b1); cyc();
        drive(1'b1, 32'h308, 1'b1, 1'b0); cyc();
        drive(1'b1, 32'h30C, 1'b0, 1'b0); cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(3);
        chk("t5_bcnt", branch_cnt, 32'd4);
        chk("t5_mcnt", mispred_cnt, 32'd2);

        // 6: reset mid-operation
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 1'b1, 1'b0);
            cyc();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t6_count_pre", 32'(count), 32'd5);
        rst = 1'b1;
        cyc();
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_uvalid", 32'(update_valid), 32'd0);
        chk("t6_bcnt", branch_cnt, 32'd0);
        chk("t6_mcnt", mispred_cnt, 32'd0);
        chk("t6_upc", update_pc, 32'h0);
        rst = 1'b0;
        hold = 1'b0;
        drive(1'b1, 32'h500, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t6_upc_fresh", update_pc, 32'h500);
        chk("t6_uvalid_fresh", 32'(update_valid), 32'd1);
        cyc(2);
        chk("t6_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
